// File: rtl/updown_ctrl_if.sv
// rtl/updown_ctrl_if.sv - button/mode/count inputs and direction outputs of updown_ctrl
//   btn_in       raw pushbutton, active-high, asynchronous
//   mode_bounce  1 = auto-reverse at count extremes, 0 = free wrap
//   count_in     count fed back from sync_counter
//   up_down      direction to sync_counter (1 = up)
//   press_pulse  one-cycle pulse per debounced press
//   dir_change   one-cycle pulse in the cycle after up_down changed
interface updown_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             btn_in;
  logic             mode_bounce;
  logic [WIDTH-1:0] count_in;
  logic             up_down;
  logic             press_pulse;
  logic             dir_change;

  modport master (
    output btn_in, mode_bounce, count_in,
    input  up_down, press_pulse, dir_change
  );

  modport slave (
    input  btn_in, mode_bounce, count_in,
    output up_down, press_pulse, dir_change
  );
endinterface

// File: rtl/updown_ctrl.sv
// rtl/updown_ctrl.sv - debounced press / bounce-mode direction controller for sync_counter
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    updown_ctrl_if slave: btn_in, mode_bounce, count_in in; up_down, press_pulse, dir_change out
module updown_ctrl #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  updown_ctrl_if.slave  bus
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0]    DEB_LAST = CW'(DEB_CYCLES - 1);
  // Lookahead thresholds: the counter moves on the same edge that samples up_down.
  localparam logic [WIDTH-1:0] UP_TURN  = WIDTH'((2 ** WIDTH) - 2);
  localparam logic [WIDTH-1:0] DN_TURN  = WIDTH'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          btn_db_q, btn_db_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_q, press_d;
  logic          up_down_q, up_down_d;
  logic          dir_change_q, dir_change_d;

  logic          mismatch;
  logic          bounce_req;
  logic          flip;

  always_comb begin
    sync1_d   = bus.btn_in;
    sync2_d   = sync1_q;
    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    mismatch  = (sync2_q != btn_db_q);

    if (mismatch) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d  = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + CW'(1);
      end
    end

    // Pulse only on a debounced 0->1 transition; release is ignored.
    press_d = btn_db_d & ~btn_db_q;

    bounce_req = bus.mode_bounce &
                 (( up_down_q & (bus.count_in >= UP_TURN)) |
                  (~up_down_q & (bus.count_in <= DN_TURN)));

    // OR, not XOR: a coincident press and bounce request invert only once.
    flip         = press_q | bounce_req;
    up_down_d    = up_down_q ^ flip;
    dir_change_d = flip;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      btn_db_q     <= 1'b0;
      deb_cnt_q    <= '0;
      press_q      <= 1'b0;
      up_down_q    <= 1'b1;
      dir_change_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      btn_db_q     <= btn_db_d;
      deb_cnt_q    <= deb_cnt_d;
      press_q      <= press_d;
      up_down_q    <= up_down_d;
      dir_change_q <= dir_change_d;
    end
  end

  assign bus.up_down     = up_down_q;
  assign bus.press_pulse = press_q;
  assign bus.dir_change  = dir_change_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// tb/tb_updown_ctrl.sv - scoreboard bench for updown_ctrl with counter feedback model
module tb_updown_ctrl;

  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int MAXV = (1 << W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  updown_ctrl_if #(.WIDTH(W)) bus ();

  updown_ctrl #(.WIDTH(W), .DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // sync_counter stand-in, or an externally forced count
  logic [W-1:0] cnt;
  logic         use_ext   = 1'b0;
  logic [W-1:0] ext_count = '0;
  assign bus.count_in = use_ext ? ext_count : cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= bus.up_down ? cnt + 1'b1 : cnt - 1'b1;
  end

  typedef struct {
    bit ud;
    bit pp;
    bit dc;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0b, required %0b", name, $time, act, req);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // Reference model: button history, mismatch run length and flip count parity.
  int m_s1, m_s2, m_db, m_run, m_press, m_flips, m_dc;
  int m_new_db, m_bounce, m_up, m_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0;
      m_press = 0; m_flips = 0; m_dc = 0;
      sb.push_back('{1'b1, 1'b0, 1'b0});
    end else begin
      m_new_db = m_db;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DEB) begin
          m_new_db = m_s2;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      m_up     = (m_flips % 2 == 0) ? 1 : 0;
      m_cnt    = int'(bus.count_in);
      m_bounce = (bus.mode_bounce === 1'b1) &&
                 ((m_up == 1 && m_cnt >= MAXV - 1) || (m_up == 0 && m_cnt <= 1)) ? 1 : 0;
      m_dc     = (m_press != 0 || m_bounce != 0) ? 1 : 0;
      if (m_dc != 0) m_flips++;
      m_press  = (m_new_db == 1 && m_db == 0) ? 1 : 0;
      m_db     = m_new_db;
      m_s2     = m_s1;
      m_s1     = (bus.btn_in === 1'b1) ? 1 : 0;
      sb.push_back('{(m_flips % 2 == 0), (m_press != 0), (m_dc != 0)});
    end
  end

  // Monitor
  int       press_seen = 0;
  bit       chk_wrap   = 0;
  int       wrap_bad   = 0;
  int       peak       = 0;
  logic [W-1:0] prev_cnt = '0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("up_down",     bus.up_down,     e.ud);
      chk("press_pulse", bus.press_pulse, e.pp);
      chk("dir_change",  bus.dir_change,  e.dc);
    end
    if (bus.press_pulse === 1'b1) press_seen++;
    if (chk_wrap) begin
      if ((prev_cnt == MAXV[W-1:0] && cnt == '0) || (prev_cnt == '0 && cnt == MAXV[W-1:0]))
        wrap_bad++;
      if (int'(cnt) > peak) peak = int'(cnt);
      // A turn at 14 lands the counter on 15; a turn at 1 lands it on 0.
      if (bus.dir_change === 1'b1)
        chk("bounce_turn_point", (cnt == (bus.up_down ? '0 : MAXV[W-1:0])), 1'b1);
    end
    prev_cnt = cnt;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    int p0;
    int hold;
    bit found;
    bus.btn_in      = 1'b0;
    bus.mode_bounce = 1'b0;

    // Button held through reset
    cyc(3);
    bus.btn_in = 1'b1;
    cyc(1);
    chk("rst_up_down", bus.up_down, 1'b1);
    chk("rst_press",   bus.press_pulse, 1'b0);
    p0 = press_seen;
    reset = 1'b0;
    cyc(12);
    chk_int("reset_held_presses", press_seen - p0, 1);
    bus.btn_in = 1'b0;
    cyc(10);

    // Clean press, free wrap
    do_reset();
    p0 = press_seen;
    bus.btn_in = 1'b1;
    cyc(10);
    bus.btn_in = 1'b0;
    cyc(12);
    chk_int("clean_presses", press_seen - p0, 1);
    chk("clean_dir", bus.up_down, 1'b0);

    // Glitch rejection
    do_reset();
    p0 = press_seen;
    repeat (5) begin
      bus.btn_in = 1'b1;
      cyc(3);
      bus.btn_in = 1'b0;
      cyc(3);
    end
    cyc(6);
    chk_int("glitch_presses", press_seen - p0, 0);
    chk("glitch_dir", bus.up_down, 1'b1);

    // Bounce ping-pong from reset
    bus.mode_bounce = 1'b1;
    reset = 1'b1;
    cyc(2);
    peak = 0;
    wrap_bad = 0;
    chk_wrap = 1;
    reset = 1'b0;
    cyc(40);
    chk_wrap = 0;
    chk_int("bounce_no_wrap", wrap_bad, 0);
    chk_int("bounce_peak", peak, MAXV);

    // Press coincident with a bounce request
    bus.mode_bounce = 1'b1;
    use_ext   = 1'b1;
    ext_count = 4'd5;
    do_reset();
    bus.btn_in = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (m_press != 0) found = 1;
    end
    chk("simul_press_found", found, 1'b1);
    ext_count = 4'(MAXV - 1);
    cyc(1);
    chk("simul_dir", bus.up_down, 1'b0);
    chk("simul_dchg", bus.dir_change, 1'b1);
    ext_count = 4'd5;
    cyc(1);
    chk("simul_dchg_once", bus.dir_change, 1'b0);
    chk("simul_dir_hold", bus.up_down, 1'b0);
    bus.btn_in = 1'b0;
    bus.mode_bounce = 1'b0;
    use_ext = 1'b0;
    cyc(10);

    // Asynchronous reset mid-debounce with up_down=0
    do_reset();
    bus.btn_in = 1'b1;
    cyc(10);
    bus.btn_in = 1'b0;
    cyc(12);
    chk("pre_async_dir", bus.up_down, 1'b0);
    bus.btn_in = 1'b1;
    cyc(4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_up_down", bus.up_down, 1'b1);
    chk("async_press",   bus.press_pulse, 1'b0);
    chk("async_dchg",    bus.dir_change, 1'b0);
    cyc(2);
    p0 = press_seen;
    reset = 1'b0;
    cyc(12);
    chk_int("requalify_presses", press_seen - p0, 1);
    bus.btn_in = 1'b0;
    cyc(10);

    // Randomized: counter feedback with mode changes
    do_reset();
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        bus.btn_in = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      if ($urandom_range(0, 59) == 0) bus.mode_bounce = ~bus.mode_bounce;
      cyc(1);
    end

    // Randomized: arbitrary count values
    use_ext = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        bus.btn_in = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 9));
      end
      hold--;
      ext_count = 4'($urandom_range(0, MAXV));
      if ($urandom_range(0, 39) == 0) bus.mode_bounce = ~bus.mode_bounce;
      cyc(1);
    end
    use_ext = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
